mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the pipelined CPU's instruction-fetch port (IF stage) and data port (MEM stage).
- Sits between the CPU and the memory model and serialises the two ports.
- Each requester holds its request until a one-cycle ack; the CPU stalls the requesting stage while the ack is low.
- Data accesses win by default. A streak limit guarantees that fetch is not starved.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Serialises the CPU fetch port and data port onto one single-ported memory.
// Data wins by default; a streak limit keeps fetch from starving.
module mem_port_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          bus_err,
    output logic          grant_dm,
    output logic [1:0]    fsm_state
);

    // Handshake: a requester holds req (and its address/data) until it sees a
    // one-cycle ack; toward memory, mem_req stays high until mem_ack or timeout.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam bit         TMO_EN     = (TIMEOUT != 0);
    localparam logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF);

    state_t        state, state_nx;
    logic [3:0]    streak, streak_nx;
    logic [7:0]    tmo_cnt, tmo_cnt_nx;
    logic          mem_req_nx, mem_we_nx, if_ack_nx, dm_ack_nx, bus_err_nx, grant_dm_nx;
    logic [AW-1:0] mem_addr_nx;
    logic [DW-1:0] mem_wdata_nx, if_rdata_nx, dm_rdata_nx;
    logic          pick_dm;

    // Byte offsets are discarded by word alignment.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

    assign fsm_state = state;
    assign pick_dm   = dm_req && (!if_req || (streak < STREAK_MAX));

    always_comb begin
        state_nx     = state;
        streak_nx    = streak;
        tmo_cnt_nx   = tmo_cnt;
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        if_rdata_nx  = if_rdata;
        dm_rdata_nx  = dm_rdata;
        grant_dm_nx  = grant_dm;
        if_ack_nx    = 1'b0;
        dm_ack_nx    = 1'b0;
        bus_err_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    state_nx    = BUSY;
                    mem_req_nx  = 1'b1;
                    tmo_cnt_nx  = 8'd0;
                    grant_dm_nx = pick_dm;
                    if (pick_dm) begin
                        mem_we_nx    = dm_we;
                        mem_addr_nx  = {dm_addr[AW-1:2], 2'b00};
                        mem_wdata_nx = dm_wdata;
                        // Only a waiting fetch makes a data grant count toward the limit.
                        if (!if_req)
                            streak_nx = 4'd0;
                        else if (streak != 4'hF)
                            streak_nx = streak + 4'd1;
                    end else begin
                        mem_we_nx    = 1'b0;
                        mem_addr_nx  = {if_addr[AW-1:2], 2'b00};
                        mem_wdata_nx = '0;
                        streak_nx    = 4'd0;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_nx   = RESP;
                    mem_req_nx = 1'b0;
                    if (grant_dm) begin
                        dm_rdata_nx = mem_rdata;
                        dm_ack_nx   = 1'b1;
                    end else begin
                        if_rdata_nx = mem_rdata;
                        if_ack_nx   = 1'b1;
                    end
                end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                    state_nx   = RESP;
                    mem_req_nx = 1'b0;
                    bus_err_nx = 1'b1;
                    if (grant_dm) begin
                        dm_rdata_nx = ERR_DATA;
                        dm_ack_nx   = 1'b1;
                    end else begin
                        if_rdata_nx = ERR_DATA;
                        if_ack_nx   = 1'b1;
                    end
                end else begin
                    tmo_cnt_nx = tmo_cnt + 8'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            streak    <= 4'd0;
            tmo_cnt   <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            bus_err   <= 1'b0;
            grant_dm  <= 1'b0;
        end else begin
            state     <= state_nx;
            streak    <= streak_nx;
            tmo_cnt   <= tmo_cnt_nx;
            mem_req   <= mem_req_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            if_rdata  <= if_rdata_nx;
            dm_rdata  <= dm_rdata_nx;
            if_ack    <= if_ack_nx;
            dm_ack    <= dm_ack_nx;
            bus_err   <= bus_err_nx;
            grant_dm  <= grant_dm_nx;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two requester drivers, a memory model with
// configurable wait states and a transaction-level scoreboard.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAXS = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          bus_err, grant_dm;
    logic [1:0]    fsm_state;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DM_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_err(bus_err), .grant_dm(grant_dm), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus queues
    logic [31:0] if_q[$];
    logic        dm_we_q[$];
    logic [31:0] dm_addr_q[$];
    logic [31:0] dm_wd_q[$];
    int          wait_q[$];
    logic [31:0] mem_arr[logic [31:0]];
    logic        grant_log[$];
    logic [31:0] addr_log[$];

    // reference model state
    bit          rand_mode = 0;
    bit          m_busy = 0, exp_rise = 0, exp_if_ack = 0, exp_dm_ack = 0, exp_err = 0;
    bit          m_grant_dm = 0, exp_port_dm = 0, exp_we = 0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, m_if_rdata = '0, m_dm_rdata = '0;
    int          mcnt = 0, wait_cyc = 0, free_cnt = 0, streak = 0, if_gap = 0, dm_gap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic int pending();
        return if_q.size() + dm_addr_q.size() + int'(if_req) + int'(dm_req) + int'(m_busy)
             + int'(exp_rise) + free_cnt + int'(exp_if_ack) + int'(exp_dm_ack);
    endfunction

    task automatic complete(input logic [31:0] d, input bit err);
        if (exp_port_dm) begin
            exp_dm_ack = 1;
            m_dm_rdata = d;
        end else begin
            exp_if_ack = 1;
            m_if_rdata = d;
        end
        exp_err  = err;
        m_busy   = 0;
        free_cnt = 3;
    endtask

    task automatic model_reset();
        m_busy = 0; exp_rise = 0; exp_if_ack = 0; exp_dm_ack = 0; exp_err = 0;
        m_grant_dm = 0; m_if_rdata = '0; m_dm_rdata = '0;
        mcnt = 0; free_cnt = 0; streak = 0; if_gap = 0; dm_gap = 0;
        if_req = 0; dm_req = 0;
        if_q.delete(); dm_we_q.delete(); dm_addr_q.delete(); dm_wd_q.delete(); wait_q.delete();
    endtask

    // One clock cycle: check outputs, move requesters and memory, predict.
    task automatic step();
        bit          ack_now, tmo;
        logic [31:0] rd;
        @(negedge clk);
        check("if_ack", if_ack, exp_if_ack);
        check("dm_ack", dm_ack, exp_dm_ack);
        check("bus_err", bus_err, exp_err);
        check("if_rdata", if_rdata, m_if_rdata);
        check("dm_rdata", dm_rdata, m_dm_rdata);
        check("grant_dm", grant_dm, m_grant_dm);

        if (exp_if_ack) begin
            if_req = 0;
            if_gap = rand_mode ? int'($urandom_range(0, 3)) : 0;
        end
        if (exp_dm_ack) begin
            dm_req = 0;
            dm_gap = rand_mode ? int'($urandom_range(0, 3)) : 0;
        end
        exp_if_ack = 0; exp_dm_ack = 0; exp_err = 0;
        if (!if_req) begin
            if (if_gap > 0) if_gap--;
            else if (if_q.size() > 0) begin
                if_addr = if_q.pop_front();
                if_req  = 1;
            end
        end
        if (!dm_req) begin
            if (dm_gap > 0) dm_gap--;
            else if (dm_addr_q.size() > 0) begin
                dm_we    = dm_we_q.pop_front();
                dm_addr  = dm_addr_q.pop_front();
                dm_wdata = dm_wd_q.pop_front();
                dm_req   = 1;
            end
        end

        if (m_busy) begin
            check("mem_req_hold", mem_req, 1);
            check("mem_addr_hold", mem_addr, exp_addr);
            check("mem_we_hold", mem_we, exp_we);
        end else begin
            check("mem_req", mem_req, exp_rise);
            if (exp_rise) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_we", mem_we, exp_we);
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
                grant_log.push_back(grant_dm);
                addr_log.push_back(mem_addr);
                m_busy   = 1;
                exp_rise = 0;
                mcnt     = 0;
                if (wait_q.size() > 0) wait_cyc = wait_q.pop_front();
                else if (!rand_mode) wait_cyc = 0;
                else begin
                    case ($urandom_range(0, 9))
                        5, 6:    wait_cyc = int'($urandom_range(1, 3));
                        7:       wait_cyc = TMO - 1;
                        8:       wait_cyc = 255;
                        9:       wait_cyc = TMO - 2;
                        default: wait_cyc = 0;
                    endcase
                end
            end
        end

        if (m_busy) begin
            ack_now   = (mcnt == wait_cyc);
            tmo       = !ack_now && (mcnt == TMO - 1);
            rd        = mem_read(exp_addr);
            mem_ack   = ack_now;
            mem_rdata = ack_now ? rd : $urandom;
            if (ack_now) begin
                if (exp_we) mem_arr[exp_addr] = exp_wdata;
                complete(rd, 0);
            end else if (tmo) begin
                complete(32'hDEADBEEF, 1);
            end else begin
                mcnt++;
            end
        end else begin
            mem_ack   = rand_mode && ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end

        if (free_cnt > 0) free_cnt--;
        if (free_cnt == 0 && !m_busy && !exp_rise && (if_req || dm_req)) begin
            exp_port_dm = dm_req && (!if_req || streak < MAXS);
            if (exp_port_dm) begin
                exp_we    = dm_we;
                exp_addr  = dm_addr & 32'hFFFF_FFFC;
                exp_wdata = dm_wdata;
                streak    = if_req ? ((streak < 15) ? streak + 1 : 15) : 0;
            end else begin
                exp_we   = 0;
                exp_addr = if_addr & 32'hFFFF_FFFC;
                streak   = 0;
            end
            m_grant_dm = exp_port_dm;
            exp_rise   = 1;
        end
    endtask

    task automatic run(input int max_cycles);
        int n;
        n = 0;
        while (pending() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        check("drain", pending(), 0);
    endtask

    task automatic push_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
        dm_we_q.push_back(we);
        dm_addr_q.push_back(a);
        dm_wd_q.push_back(d);
    endtask

    task automatic check_trace(input string tag, input logic [5:0] exp);
        logic [5:0] got;
        got = '0;
        for (int i = 0; i < 6 && i < grant_log.size(); i++) got[5-i] = grant_log[i];
        check({tag, "_len"}, (grant_log.size() >= 6) ? 1 : 0, 1);
        check(tag, got, exp);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_dm_ack", dm_ack, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_grant_dm", grant_dm, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_state", fsm_state, 0);
        rst = 1;

        // single fetch, zero wait
        mem_arr[32'h3004] = 32'h2008_0005;
        if_q.push_back(32'h3004);
        run(50);
        check("fetch_rdata", if_rdata, 32'h2008_0005);
        check("fetch_addr", addr_log[0], 32'h3004);

        // simultaneous fetch and store: store first
        grant_log.delete(); addr_log.delete();
        if_q.push_back(32'h3008);
        push_dm(1, 32'h50, 32'h7);
        run(50);
        check("simul_first_dm", grant_log[0], 1);
        check("simul_second_if", grant_log[1], 0);
        check("simul_store_addr", addr_log[0], 32'h50);
        check("simul_mem_written", mem_arr[32'h50], 32'h7);

        // starvation guard
        grant_log.delete();
        if_q.push_back(32'h100);
        for (int i = 0; i < 6; i++) push_dm(0, 32'h200 + 32'(i * 4), 0);
        run(200);
        check_trace("starve_trace", 6'b111101);

        // wait states, timeout, ack on the last allowed cycle
        wait_q.push_back(3);
        push_dm(0, 32'h60, 0);
        run(50);
        wait_q.push_back(255);
        push_dm(0, 32'h64, 0);
        run(50);
        check("timeout_rdata", dm_rdata, 32'hDEADBEEF);
        wait_q.push_back(TMO - 1);
        push_dm(0, 32'h68, 0);
        run(50);
        check("late_ack_rdata", dm_rdata, mem_read(32'h68));

        // unaligned address
        addr_log.delete();
        push_dm(0, 32'h57, 0);
        run(50);
        check("unaligned", addr_log[0], 32'h54);

        // reset while BUSY
        if_q.push_back(32'h400);
        wait_q.push_back(255);
        push_dm(0, 32'h70, 0);
        for (int i = 0; i < 40 && !(m_busy && mcnt >= 3); i++) step();
        check("busy_before_rst", mem_req, 1);
        #2 rst = 0;
        #1;
        check("rst_async_mem_req", mem_req, 0);
        check("rst_async_state", fsm_state, 0);
        model_reset();
        step();
        step();
        rst = 1;
        repeat (3) step();
        grant_log.delete();
        if_q.push_back(32'h500);
        for (int i = 0; i < 6; i++) push_dm(0, 32'h300 + 32'(i * 4), 0);
        run(200);
        check_trace("post_rst_trace", 6'b111101);

        // randomized mix
        rand_mode = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 0)
                if_q.push_back(32'h1000 + 32'($urandom_range(0, 255)));
            else
                push_dm(1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 63)), $urandom);
        end
        run(20000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
